// File: rtl/hammer_resp_misr.sv
// hammer_resp_misr: response compactor for a combinational hammer test case.
//
// Each accepted valid/ready beat of the test-case output word is folded into a
// Galois MISR. After NUM_VEC accepted beats the block stops and holds the
// signature. It then flags pass/fail against an expected signature, so a
// simulation and a netlist can be compared with a single word.
//
// Ports:
//   clk      in   1        sole clock, rising edge
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        pulse: (re)start a run; in RUN this aborts and reseeds
//   in_valid in   1        response beat valid
//   in_ready out  1        block accepts a beat this cycle
//   in_data  in   WIDTH    response word
//   exp_sig  in   WIDTH    expected final signature, held stable while done=1
//   sig      out  WIDTH    current signature register
//   vec_cnt  out  CNT_W    beats accepted in the current run
//   busy     out  1        run in progress
//   done     out  1        run complete, signature frozen
//   pass     out  1        done and signature matches exp_sig
module hammer_resp_misr #(
    parameter int unsigned     WIDTH   = 31,
    parameter int unsigned     NUM_VEC = 256,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(32'h0000_0009),
    parameter logic [WIDTH-1:0] SEED   = '0,
    localparam int unsigned    CNT_W   = $clog2(NUM_VEC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] exp_sig,
    output logic [WIDTH-1:0] sig,
    output logic [CNT_W-1:0] vec_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_VEC - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    // Multiply by x modulo the feedback polynomial: shift left, fold the
    // outgoing MSB back in through the taps. Pure XOR, no carries.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);
    endfunction

    // A start pulse in RUN takes priority over any beat, so the handshake is
    // withheld that cycle and upstream keeps its beat for the fresh run.
    assign in_ready = (state_q == StRun) && !start;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    sig_d   = SEED;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (start) begin
                    sig_d = SEED;
                    cnt_d = '0;
                end else if (accept) begin
                    sig_d = misr_step(sig_q) ^ in_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                sig_d   = SEED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sig_q   <= SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sig     = sig_q;
    assign vec_cnt = cnt_q;
    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign pass    = (state_q == StDone) && (sig_q == exp_sig);

endmodule
